// File: rtl/id_ex_register.sv
`default_nettype none
//============================================================================
// Module      : id_ex_register
// Description : ID/EX pipeline register for a 5-stage MIPS-style core.
//               Captures decoded control, operands, register numbers and
//               the function field from ID and presents them to EX one
//               cycle later. Supports global freeze (Hold), bubble
//               insertion (Stall / Flush) and a saturating bubble counter.
//
//               Per-edge priority: Reset > Hold > Flush/Stall > Load.
//
// Ports       : Clk            - rising-edge clock
//               Reset          - synchronous active-high reset
//               Stall          - load-use bubble request (hazard unit)
//               Flush          - squash request (branch/jump resolution)
//               Hold           - global pipeline freeze
//               *_ID           - decoded instruction fields from ID
//               *_EX           - registered copies of the *_ID fields
//               Valid_EX       - EX slot holds a real instruction
//               BubbleCount    - saturating count of inserted bubbles
// Revision    : 1.0 - initial release
//============================================================================
module id_ex_register (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        Stall,
    input  logic        Flush,
    input  logic        Hold,
    input  logic        RegDst_ID,
    input  logic        ALUSrc_ID,
    input  logic        MemRead_ID,
    input  logic        MemWrite_ID,
    input  logic        RegWrite_ID,
    input  logic        MemtoReg_ID,
    input  logic [1:0]  ALUOp_ID,
    input  logic [31:0] ReadData1_ID,
    input  logic [31:0] ReadData2_ID,
    input  logic [31:0] SignExt_ID,
    input  logic [4:0]  Rs_ID,
    input  logic [4:0]  Rt_ID,
    input  logic [4:0]  Rd_ID,
    input  logic [5:0]  Funct_ID,
    output logic        RegDst_EX,
    output logic        ALUSrc_EX,
    output logic        MemRead_EX,
    output logic        MemWrite_EX,
    output logic        RegWrite_EX,
    output logic        MemtoReg_EX,
    output logic [1:0]  ALUOp_EX,
    output logic [31:0] ReadData1_EX,
    output logic [31:0] ReadData2_EX,
    output logic [31:0] SignExt_EX,
    output logic [4:0]  Rs_EX,
    output logic [4:0]  Rt_EX,
    output logic [4:0]  Rd_EX,
    output logic [5:0]  Funct_EX,
    output logic        Valid_EX,
    output logic [15:0] BubbleCount
);

    localparam logic [15:0] c_BC_MAX = 16'hFFFF;

    // Stall and Flush on the same edge produce a single bubble.
    logic w_bubble;
    assign w_bubble = Stall | Flush;

    // Every output is a flop; bubbles write constant zeros so unknown ID
    // values seen during a bubble or freeze can never reach EX.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            RegDst_EX    <= 1'b0;
            ALUSrc_EX    <= 1'b0;
            MemRead_EX   <= 1'b0;
            MemWrite_EX  <= 1'b0;
            RegWrite_EX  <= 1'b0;
            MemtoReg_EX  <= 1'b0;
            ALUOp_EX     <= 2'b00;
            ReadData1_EX <= 32'h0;
            ReadData2_EX <= 32'h0;
            SignExt_EX   <= 32'h0;
            Rs_EX        <= 5'd0;
            Rt_EX        <= 5'd0;
            Rd_EX        <= 5'd0;
            Funct_EX     <= 6'd0;
            Valid_EX     <= 1'b0;
            BubbleCount  <= 16'h0;
        end else if (!Hold) begin
            if (w_bubble) begin
                // Clearing MemRead_EX and Rt_EX breaks the load-use
                // comparison next cycle so a stall cannot re-trigger itself.
                RegDst_EX    <= 1'b0;
                ALUSrc_EX    <= 1'b0;
                MemRead_EX   <= 1'b0;
                MemWrite_EX  <= 1'b0;
                RegWrite_EX  <= 1'b0;
                MemtoReg_EX  <= 1'b0;
                ALUOp_EX     <= 2'b00;
                ReadData1_EX <= 32'h0;
                ReadData2_EX <= 32'h0;
                SignExt_EX   <= 32'h0;
                Rs_EX        <= 5'd0;
                Rt_EX        <= 5'd0;
                Rd_EX        <= 5'd0;
                Funct_EX     <= 6'd0;
                Valid_EX     <= 1'b0;
                if (BubbleCount != c_BC_MAX) begin
                    BubbleCount <= BubbleCount + 16'd1;
                end
            end else begin
                RegDst_EX    <= RegDst_ID;
                ALUSrc_EX    <= ALUSrc_ID;
                MemRead_EX   <= MemRead_ID;
                MemWrite_EX  <= MemWrite_ID;
                RegWrite_EX  <= RegWrite_ID;
                MemtoReg_EX  <= MemtoReg_ID;
                ALUOp_EX     <= ALUOp_ID;
                ReadData1_EX <= ReadData1_ID;
                ReadData2_EX <= ReadData2_ID;
                SignExt_EX   <= SignExt_ID;
                Rs_EX        <= Rs_ID;
                Rt_EX        <= Rt_ID;
                Rd_EX        <= Rd_ID;
                Funct_EX     <= Funct_ID;
                Valid_EX     <= 1'b1;
            end
        end
    end

endmodule
`default_nettype wire
